// File: rtl/seg_scan_pkg.sv
// Shared types and glyph table for the seven-segment scan capture block.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam int         NUM_POS  = 8;
  localparam logic [7:0] SEP_MASK = 8'b0010_0100;

  // Active-low g..a patterns for decimal glyphs
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;

  // Returns {valid, bcd}; valid is 0 for any non-decimal pattern.
  function automatic logic [4:0] glyph_to_bcd(input logic [6:0] g);
    logic [4:0] r;
    r = 5'b0_0000;
    case (g)
      GLYPH_0: r = {1'b1, 4'd0};
      GLYPH_1: r = {1'b1, 4'd1};
      GLYPH_2: r = {1'b1, 4'd2};
      GLYPH_3: r = {1'b1, 4'd3};
      GLYPH_4: r = {1'b1, 4'd4};
      GLYPH_5: r = {1'b1, 4'd5};
      GLYPH_6: r = {1'b1, 4'd6};
      GLYPH_7: r = {1'b1, 4'd7};
      GLYPH_8: r = {1'b1, 4'd8};
      GLYPH_9: r = {1'b1, 4'd9};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
module seg_sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed 8-digit seven-segment scan bus, decodes each settled
// glyph to BCD and publishes complete HH.MM.SS frames with a valid strobe.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter bit CS_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cs_i,
  input  logic [7:0]  seg_i,
  output logic [31:0] digits_o,
  output logic [7:0]  dots_o,
  output logic        frame_valid_o,
  output logic        err_glyph_o,
  output logic        err_cs_o,
  output logic        err_range_o
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  function automatic logic [7:0] bcd_pair(input logic [3:0] t, input logic [3:0] u);
    return ({4'd0, t} * 8'd10) + {4'd0, u};
  endfunction

  // Normalizing before the synchronizer makes a reset-cleared sync read as "no select".
  logic [7:0]  cs_norm;
  logic [15:0] bus_s;
  logic [7:0]  cs_s;
  logic [7:0]  seg_s;

  assign cs_norm = CS_ACTIVE_LOW ? ~cs_i : cs_i;

  seg_sync2 #(.W(16)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({cs_norm, seg_i}),
    .q_o   (bus_s)
  );

  assign cs_s  = bus_s[15:8];
  assign seg_s = bus_s[7:0];

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] prev_q;
  logic        changed;
  logic        do_cap;

  assign changed = (bus_s != prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_cap  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_s != 8'd0) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (cs_s == 8'd0) begin
          state_d = ST_IDLE;
        end else if (changed) begin
          cnt_d = 8'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // A change landing on the capture cycle itself is treated as a glitch.
      ST_CAPTURE: begin
        if (cs_s == 8'd0) begin
          state_d = ST_IDLE;
        end else if (changed) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd0;
        end else begin
          do_cap  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cs_s == 8'd0) begin
          state_d = ST_IDLE;
        end else if (changed) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [31:0] sh_dig_q, sh_dig_d;
  logic [7:0]  sh_dot_q, sh_dot_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  dots_q, dots_d;
  logic        fv_q, fv_d;
  logic        eg_q, eg_d;
  logic        ec_q, ec_d;
  logic        er_q, er_d;

  logic        onehot;
  logic [2:0]  pos;
  logic [4:0]  dec;
  logic        good;
  logic [7:0]  hh, mm, ss;

  always_comb begin
    sh_dig_d = sh_dig_q;
    sh_dot_d = sh_dot_q;
    mask_d   = mask_q;
    digits_d = digits_q;
    dots_d   = dots_q;
    fv_d     = 1'b0;
    eg_d     = eg_q;
    ec_d     = ec_q;
    er_d     = er_q;
    onehot   = (cs_s != 8'd0) && ((cs_s & (cs_s - 8'd1)) == 8'd0);
    dec      = glyph_to_bcd(seg_s[6:0]);
    good     = 1'b1;
    hh       = 8'd0;
    mm       = 8'd0;
    ss       = 8'd0;
    pos      = 3'd0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (cs_s[i]) pos = 3'(i);
    end

    if (do_cap) begin
      if (!onehot) begin
        ec_d   = 1'b1;
        mask_d = 8'd0;
      end else begin
        // Separator positions carry only the dp; their glyph is never decoded.
        if (!SEP_MASK[pos]) begin
          if (dec[4]) sh_dig_d[{pos, 2'b00} +: 4] = dec[3:0];
          else        good = 1'b0;
        end
        if (good) begin
          sh_dot_d[pos] = ~seg_s[7];
          mask_d[pos]   = 1'b1;
        end else begin
          eg_d   = 1'b1;
          mask_d = 8'd0;
        end
        if (pos == 3'd7) begin
          if (mask_d == 8'hFF) begin
            digits_d = sh_dig_d;
            dots_d   = sh_dot_d;
            fv_d     = 1'b1;
            hh = bcd_pair(sh_dig_d[3:0],   sh_dig_d[7:4]);
            mm = bcd_pair(sh_dig_d[15:12], sh_dig_d[19:16]);
            ss = bcd_pair(sh_dig_d[27:24], sh_dig_d[31:28]);
            if (hh > 8'd23 || mm > 8'd59 || ss > 8'd59) er_d = 1'b1;
          end
          mask_d = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      prev_q   <= 16'd0;
      sh_dig_q <= 32'd0;
      sh_dot_q <= 8'd0;
      mask_q   <= 8'd0;
      digits_q <= 32'd0;
      dots_q   <= 8'd0;
      fv_q     <= 1'b0;
      eg_q     <= 1'b0;
      ec_q     <= 1'b0;
      er_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= bus_s;
      sh_dig_q <= sh_dig_d;
      sh_dot_q <= sh_dot_d;
      mask_q   <= mask_d;
      digits_q <= digits_d;
      dots_q   <= dots_d;
      fv_q     <= fv_d;
      eg_q     <= eg_d;
      ec_q     <= ec_d;
      er_q     <= er_d;
    end
  end

  assign digits_o      = digits_q;
  assign dots_o        = dots_q;
  assign frame_valid_o = fv_q;
  assign err_glyph_o   = eg_q;
  assign err_cs_o      = ec_q;
  assign err_range_o   = er_q;

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive side of the multiplexed 8-digit seven-segment scan bus driven by the clock display path. Samples the one-hot digit select and segment lines and decodes each glyph back to BCD. Reassembles a full HH.MM.SS frame and publishes it with a one-cycle valid strobe. Used as an on-board loopback monitor and as the bench-side checker for display logic.

## Interface
- `SETTLE_CYCLES`, 16: cycles a select/segment pair must stay unchanged before capture (1..255).
- `CS_ACTIVE_LOW`, 1: 1 = `cs` active-low, 0 = active-high.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `cs` in 8: digit select, one-hot when valid; bit i selects position i (0 = hour tens … 7 = second units); asynchronous to `clk`.
- `seg` in 8: segments, active-low; bit 7 = dp, bits 6:0 = g..a; asynchronous.
- `digits` out 32: published BCD, nibble i = position i; positions 2/5 always 0.
- `dots` out 8: published dp state per position (1 = lit).
- `frame_valid` out 1: one-cycle pulse when `digits`/`dots` update.
- `err_glyph` out 1: sticky; non-decimal glyph at a digit position.
- `err_cs` out 1: sticky; settled `cs` not one-hot and not all-inactive.
- `err_range` out 1: sticky; completed frame with hours > 23, minutes > 59 or seconds > 59.

## Operation
- Inputs pass through a 2-flop synchronizer; all logic uses synchronized copies. `cs` normalized to active-high internally.
- FSM:
  - IDLE: enters SETTLE when normalized `cs` ≠ 0.
  - SETTLE: counter loads 0 on entry and on any change of `{cs,seg}`. Goes to CAPTURE when the counter reaches `SETTLE_CYCLES-1`. Goes to IDLE if `cs` returns to 0.
  - CAPTURE: single cycle. Decode and store, then go to HOLD.
  - HOLD: returns to SETTLE when `{cs,seg}` changes to a nonzero select, or to IDLE when `cs` = 0. No second capture while in HOLD.
- Decode table (seg[6:0]): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h. dp = ~seg[7].
- At positions 0,1,3,4,6,7, any other pattern sets `err_glyph` and clears the frame mask. Positions 2/5 record dp only; the glyph is ignored.
- Non-one-hot settled `cs` at CAPTURE: sets `err_cs`, clears the mask, stores nothing.
- Good capture: writes shadow nibble and dp, sets mask bit i.
- Capture of position 7 with mask = FFh after the update:
  - copy shadow to outputs and pulse `frame_valid`;
  - check range on shadow hh = 10·d0+d1, mm = 10·d3+d4, ss = 10·d6+d7; on failure set `err_range`, but outputs still publish;
  - clear mask.
- A position recaptured before frame completion overwrites its shadow value; mask unchanged.
- Capture of position 7 with an incomplete mask: no publish; mask cleared, so the next frame starts clean.
- Sticky errors clear only on reset.

## Timing
- Reset values: `digits` 0, `dots` 0, `frame_valid` 0, all `err_*` 0, FSM IDLE, mask 0, synchronizers 0 (cs normalized inactive).
- Input-to-capture latency: 2 (sync) + `SETTLE_CYCLES` + 1 cycles after the last input edge.
- Outputs and `frame_valid` are registered. They update on the edge following CAPTURE of position 7.
- A dwell shorter than `SETTLE_CYCLES`+2 cycles is never captured (glitch rejection).
- Reset asserted mid-frame: all state returns to reset values on the next edge. A partial frame is discarded.
- Nominal display scan is 1 ms per digit, far longer than settle. Back-to-back selects with zero blanking are legal: the `{cs,seg}` change restarts SETTLE.

## Structure
- `seg_scan_pkg`: FSM state enum; 7-bit glyph constants; `NUM_POS = 8`; `SEP_MASK = 8'b0010_0100`; function `glyph_to_bcd` returning {valid, nibble}.
- One sub-module: `seg_sync2` (parameterized-width 2-flop synchronizer), instanced once for the 16-bit `{cs,seg}` bus.

## Test plan
- Scan 12:34:56 (separators with dp lit), 1 ms per digit, `cs` active-low → one `frame_valid` per 8-digit sweep; `digits` = 6_5_0_4_3_0_2_1 (pos7..0 nibbles); `dots` = 24h; no errors.
- A 5-cycle `seg` glitch on position 4 mid-dwell, with SETTLE_CYCLES = 16 → captured value unchanged; `frame_valid` timing unchanged.
- Pos 3 glyph 7Fh (blank) → `err_glyph` = 1; the next full sweep of 12:34:56 publishes correctly; `err_glyph` stays 1.
- `cs` = 0Ch held stable → `err_cs` = 1, mask cleared; no `frame_valid` until a complete sweep follows.
- Sweep 25:61:00 → `frame_valid` pulses, `digits` show 25:61:00, `err_range` = 1.
- Reset pulsed after positions 0–4 → all outputs 0; sweep resumes at position 5; the first `frame_valid` occurs only after the next complete 0–7 sweep.
